ym_dbg_write: RTL and testbench
===============================

YM_DBG_WRITE -- requirements
Module: ym_dbg_write

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, legal range 2..32, giving the serial frame length and parallel word width.
REQ-002 The block SHALL have input MCLK, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have input load, 1 bit: frame-start strobe, sampled each MCLK.
REQ-005 The block SHALL have input shift, 1 bit: bit strobe, where one MCLK high equals one bit accepted.
REQ-006 The block SHALL have input sin, 1 bit: serial data, LSB first, valid when shift=1.
REQ-007 The block SHALL have input clr_err, 1 bit: clears overrun.
REQ-008 The block SHALL have output data, DATA_WIDTH bits: last committed word, registered.
REQ-009 The block SHALL have output valid, 1 bit: one-cycle commit pulse, registered.
REQ-010 The block SHALL have output busy, 1 bit: high while a frame is being assembled.
REQ-011 The block SHALL have output overrun, 1 bit: sticky protocol-error flag, registered.

Function
REQ-012 The block SHALL implement a serial-in/parallel-out debug-chain writer, the receiving end of an LSB-first debug readout chain.
REQ-013 The block SHALL implement two states, IDLE and SHIFT; busy SHALL be 1 exactly when the state is SHIFT.
REQ-014 In IDLE, load=1 SHALL move the state to SHIFT, zero the bit counter and zero the shift register; a shift strobe in the same cycle SHALL be discarded without error.
REQ-015 In IDLE, shift=1 with load=0 SHALL set overrun and SHALL leave data and the counter unchanged.
REQ-016 In SHIFT, shift=1 SHALL load sin into the shift register MSB, move the existing contents right by one, and increment the counter.
REQ-017 The counter SHALL be ceil(log2(DATA_WIDTH)) bits wide and SHALL never wrap within a frame.
REQ-018 On the edge that accepts bit DATA_WIDTH-1 (the counter equals DATA_WIDTH-1 and shift=1), the block SHALL:
- load data with the assembled word {sin, sr[DATA_WIDTH-1:1]};
- assert valid for exactly the following cycle;
- return the state to IDLE.
REQ-019 Commit latency SHALL be 1 MCLK from the final shift strobe to data/valid; gaps of any length between shift strobes SHALL be allowed.
REQ-020 In SHIFT, load=1 (with or without shift) SHALL restart the frame as in REQ-014, SHALL set overrun, and SHALL discard any coincident bit.
REQ-021 Between commits, data SHALL hold its value; a partial frame SHALL never alter data.
REQ-022 overrun SHALL stay set until clr_err=1; when a set event and clr_err coincide, set SHALL win.
REQ-023 Back-to-back frames SHALL be supported: load in the cycle in which valid=1 SHALL start a new frame with no error.

Reset
REQ-024 While reset=0, asynchronously, the block SHALL force: state to IDLE, counter to 0, shift register to 0, data to 0, valid to 0, overrun to 0, busy to 0.
REQ-025 After reset deassertion, the first rising edge SHALL process inputs normally.
REQ-026 Reset asserted mid-frame SHALL abandon the frame silently, with no valid and no overrun.

Structure
REQ-027 The shared package ym_dbg_pkg SHALL hold:
- the state encoding constants (IDLE=0, SHIFT=1);
- the counter-width function, which is shared with the readout side.
REQ-028 The bit counter with its terminal-count compare SHALL be one sub-module, ym_dbg_bitcnt (inputs: clear, increment; output: terminal count).
REQ-029 Apart from REQ-028, the block SHALL be flat, with no other sub-modules.

Verification (DATA_WIDTH=16)
REQ-030 Scenario: load, then 16 shifts carrying 0xA5C3 LSB first, with random 0..3 cycle gaps -> data=0xA5C3 and valid high for exactly 1 cycle, 1 MCLK after the 16th shift; busy falls on the same edge; overrun=0.
REQ-031 Scenario: a stray shift in IDLE with data=0xA5C3 -> overrun=1, data stays 0xA5C3, valid stays 0.
REQ-032 Scenario: load, 5 bits, load, then 16 bits of 0x1234 -> one valid, data=0x1234, overrun=1.
REQ-033 Scenario: reset=0 pulse after 8 bits of a frame -> all outputs 0 immediately, with no clock needed; the next full frame of 0xFFFF commits correctly.
REQ-034 Scenario: clr_err=1 coincident with a stray shift in IDLE -> overrun=1; clr_err alone on the next cycle -> overrun=0.
REQ-035 Scenario: two frames 0x0001 and 0x8000, with the second load in the valid cycle of the first -> two valid pulses, data sequence 0x0001 then 0x8000, overrun=0.

Source files
------------

// File: rtl/ym_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ym_dbg_pkg
// Description : State encoding and counter sizing shared by the debug-chain
//               writer and the readout side.
// Revision    : 1.0  initial release
// ============================================================================
package ym_dbg_pkg;

    localparam logic c_ST_IDLE  = 1'b0;
    localparam logic c_ST_SHIFT = 1'b1;

    typedef enum logic {
        ST_IDLE  = c_ST_IDLE,
        ST_SHIFT = c_ST_SHIFT
    } state_e;

    // Bits needed to count 0..width-1; never less than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ym_dbg_bitcnt.sv
`default_nettype none
// ============================================================================
// Module      : ym_dbg_bitcnt
// Description : Frame bit counter with terminal-count compare.
// Revision    : 1.0  initial release
// ============================================================================
module ym_dbg_bitcnt
    import ym_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_increment,
    output logic o_terminal
);

    localparam int              c_CW   = cnt_width(DATA_WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DATA_WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_cnt_q;
    logic [c_CW-1:0] w_cnt_d;

    // Saturates at the last bit so a frame can never wrap the count.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_increment && (r_cnt_q != c_LAST)) begin
            w_cnt_d = r_cnt_q + c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_terminal = (r_cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ym_dbg_write.sv
`default_nettype none
// ============================================================================
// Module      : ym_dbg_write
// Description : Serial-in/parallel-out receiver for an LSB-first debug chain.
// Revision    : 1.0  initial release
// ============================================================================
module ym_dbg_write
    import ym_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  sin,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  busy,
    output logic                  overrun
);

    state_e                r_state_q, w_state_d;
    logic [DATA_WIDTH-1:0] r_sr_q,    w_sr_d;
    logic [DATA_WIDTH-1:0] r_data_q,  w_data_d;
    logic                  r_valid_q, w_valid_d;
    logic                  r_ovr_q,   w_ovr_d;

    logic                  w_ovr_set;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;
    logic                  w_tc;
    logic [DATA_WIDTH-1:0] w_shifted;

    ym_dbg_bitcnt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bitcnt (
        .clk         (MCLK),
        .rst_n       (reset),
        .i_clear     (w_cnt_clr),
        .i_increment (w_cnt_inc),
        .o_terminal  (w_tc)
    );

    assign w_shifted = {sin, r_sr_q[DATA_WIDTH-1:1]};

    always_comb begin
        w_state_d = r_state_q;
        w_sr_d    = r_sr_q;
        w_data_d  = r_data_q;
        w_valid_d = 1'b0;
        w_ovr_set = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (load) begin
                    w_state_d = ST_SHIFT;
                    w_sr_d    = '0;
                    w_cnt_clr = 1'b1;
                end else if (shift) begin
                    w_ovr_set = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A load mid-frame restarts; any coincident bit is dropped.
                if (load) begin
                    w_sr_d    = '0;
                    w_cnt_clr = 1'b1;
                    w_ovr_set = 1'b1;
                end else if (shift) begin
                    w_sr_d = w_shifted;
                    if (w_tc) begin
                        w_data_d  = w_shifted;
                        w_valid_d = 1'b1;
                        w_state_d = ST_IDLE;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_ovr_d = w_ovr_set | (r_ovr_q & ~clr_err);
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            r_state_q <= ST_IDLE;
            r_sr_q    <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_ovr_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_sr_q    <= w_sr_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_ovr_q   <= w_ovr_d;
        end
    end

    assign data    = r_data_q;
    assign valid   = r_valid_q;
    assign busy    = (r_state_q == ST_SHIFT);
    assign overrun = r_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_ym_dbg_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_ym_dbg_write
// Description : Scenario and randomized bench for ym_dbg_write (16-bit frames).
// Revision    : 1.0  initial release
// ============================================================================
module tb_ym_dbg_write;

    logic        MCLK;
    logic        reset;
    logic        load;
    logic        shift;
    logic        sin;
    logic        clr_err;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic        overrun;

    int errors;
    int checks;
    int vld_seen;

    // Reference: frame bits are placed by position, outputs follow protocol rules.
    bit        m_in_frame;
    int        m_n;
    bit [15:0] m_word;
    bit [15:0] m_data;
    bit        m_valid;
    bit        m_ovr;

    ym_dbg_write #(
        .DATA_WIDTH (16)
    ) dut (
        .MCLK    (MCLK),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .sin     (sin),
        .clr_err (clr_err),
        .data    (data),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic model_reset();
        m_in_frame = 0; m_n = 0; m_word = '0;
        m_data = '0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit ld, input bit sh, input bit s, input bit ce);
        bit set_err;
        set_err = 0;
        m_valid = 0;
        if (ld) begin
            if (m_in_frame) set_err = 1;
            m_in_frame = 1; m_n = 0; m_word = '0;
        end else if (sh) begin
            if (!m_in_frame) begin
                set_err = 1;
            end else begin
                m_word[m_n] = s;
                m_n++;
                if (m_n == 16) begin
                    m_data = m_word; m_valid = 1; m_in_frame = 0;
                end
            end
        end
        if (set_err) m_ovr = 1;
        else if (ce) m_ovr = 0;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input bit ld, input bit sh, input bit s, input bit ce);
        load = ld; shift = sh; sin = s; clr_err = ce;
        model_step(ld, sh, s, ce);
        @(posedge MCLK);
        #1;
        if (valid === 1'b1) vld_seen++;
        load = 0; shift = 0; sin = 0; clr_err = 0;
    endtask

    task automatic send_bits(input bit [15:0] w, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) step(0, 0, 0, 0);
            step(0, 1, w[i], 0);
        end
    endtask

    task automatic test_reset();
        reset = 0; load = 0; shift = 0; sin = 0; clr_err = 0;
        model_reset();
        repeat (3) @(posedge MCLK);
        #1;
        checks++;
        if ({data, valid, busy, overrun} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b b=%b o=%b required all 0",
                     data, valid, busy, overrun);
        end
        reset = 1;
    endtask

    task automatic test_frame();
        int pulses;
        bit [15:0] w;
        w = 16'hA5C3;
        pulses = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) begin
                step(0, 0, 0, 0);
                if (valid === 1'b1) pulses++;
            end
            step(0, 1, w[i], 0);
            if (i < 15 && valid === 1'b1) pulses++;
        end
        checks++;
        if (data !== 16'hA5C3 || valid !== 1'b1) begin
            errors++;
            $display("FAIL frame_commit: got data=%h v=%b required data=a5c3 v=1", data, valid);
        end
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL frame_flags: got b=%b o=%b required b=0 o=0", busy, overrun);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL frame_early_valid: got %0d pulses required 0", pulses);
        end
        step(0, 0, 0, 0);
        checks++;
        if (valid !== 1'b0 || data !== 16'hA5C3) begin
            errors++;
            $display("FAIL frame_pulse_width: got v=%b data=%h required v=0 data=a5c3", valid, data);
        end
    endtask

    task automatic test_stray();
        step(0, 1, 1, 0);
        checks++;
        if (overrun !== 1'b1 || data !== 16'hA5C3 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_shift: got o=%b data=%h v=%b b=%b required o=1 data=a5c3 v=0 b=0",
                     overrun, data, valid, busy);
        end
    endtask

    task automatic test_restart();
        step(0, 0, 0, 1);
        vld_seen = 0;
        step(1, 0, 0, 0);
        send_bits(16'h001F, 5, 0);
        step(1, 1, 1, 0);
        send_bits(16'h1234, 16, 0);
        checks++;
        if (vld_seen !== 1 || data !== 16'h1234 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL restart: got pulses=%0d data=%h o=%b required pulses=1 data=1234 o=1",
                     vld_seen, data, overrun);
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        send_bits(16'h00FF, 8, 0);
        #2;
        reset = 0;
        model_reset();
        #1;
        checks++;
        if ({data, valid, busy, overrun} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got data=%h v=%b b=%b o=%b required all 0",
                     data, valid, busy, overrun);
        end
        #1;
        reset = 1;
        vld_seen = 0;
        step(1, 0, 0, 0);
        send_bits(16'hFFFF, 16, 1);
        checks++;
        if (data !== 16'hFFFF || valid !== 1'b1 || vld_seen !== 1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame: got data=%h v=%b pulses=%0d o=%b required ffff 1 1 0",
                     data, valid, vld_seen, overrun);
        end
    endtask

    task automatic test_clr_err();
        step(0, 1, 0, 1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set: got o=%b required 1", overrun);
        end
        step(0, 0, 0, 1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone: got o=%b required 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        vld_seen = 0;
        step(1, 0, 0, 0);
        send_bits(16'h0001, 16, 0);
        checks++;
        if (valid !== 1'b1 || data !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_first: got v=%b data=%h required v=1 data=0001", valid, data);
        end
        step(1, 0, 0, 0);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload: got b=%b v=%b o=%b required b=1 v=0 o=0", busy, valid, overrun);
        end
        send_bits(16'h8000, 16, 0);
        checks++;
        if (valid !== 1'b1 || data !== 16'h8000 || vld_seen !== 2 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got v=%b data=%h pulses=%0d o=%b required 1 8000 2 0",
                     valid, data, vld_seen, overrun);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 9) == 0));
            checks++;
            if (data !== m_data || valid !== m_valid || busy !== m_in_frame || overrun !== m_ovr) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle %0d: got data=%h v=%b b=%b o=%b required %h %b %b %b",
                             i, data, valid, busy, overrun, m_data, m_valid, m_in_frame, m_ovr);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vld_seen = 0;
        test_reset();
        test_frame();
        test_stray();
        test_restart();
        test_async_reset();
        test_clr_err();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
